// File: rtl/write_back.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : write_back                                                    |
// | Purpose  : MIPS writeback stage - result select, register-file write     |
// |            port and a registered copy of the last retired write.         |
// | Config   : WB_LOAD_EXT_EN enables sub-word lane select and extension.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module write_back #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memToRegW,
  input  logic              regWriteW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [REG_AW-1:0] writeRegW,
  input  logic [1:0]        loadSizeW,
  input  logic              loadUnsW,
  output logic [DATA_W-1:0] resultW,
  output logic              rfWeW,
  output logic [REG_AW-1:0] rfWaddrW,
  output logic [DATA_W-1:0] rfWdataW,
  output logic [DATA_W-1:0] lastResultQ,
  output logic [REG_AW-1:0] lastRegQ,
  output logic              lastValidQ
);

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic [DATA_W-1:0] load_data;

`ifdef WB_LOAD_EXT_EN
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;

  // Lane extraction by shifting the addressed lane down to bit 0.
  assign byte_shift = readDataW >> {ALUOutW[1:0], 3'b000};
  assign half_shift = readDataW >> {ALUOutW[1], 4'b0000};
  assign byte_lane  = byte_shift[7:0];
  assign half_lane  = half_shift[15:0];

  always_comb begin
    load_data = readDataW;
    case (loadSizeW)
      SIZE_HALF: load_data = {{(DATA_W-16){~loadUnsW & half_lane[15]}}, half_lane};
      SIZE_BYTE: load_data = {{(DATA_W-8){~loadUnsW & byte_lane[7]}}, byte_lane};
      default:   load_data = readDataW;
    endcase
  end
`else
  logic unused_load_ctrl;

  assign unused_load_ctrl = ^{loadSizeW, loadUnsW};
  assign load_data        = readDataW;
`endif

  assign resultW  = memToRegW ? load_data : ALUOutW;
  assign rfWdataW = resultW;
  assign rfWaddrW = writeRegW;
  // Reset blocks writes; $0 is hard-wired zero so its writes are dropped.
  assign rfWeW    = rst_n & regWriteW & (writeRegW != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastResultQ <= '0;
      lastRegQ    <= '0;
      lastValidQ  <= 1'b0;
    end else if (rfWeW) begin
      lastResultQ <= resultW;
      lastRegQ    <= writeRegW;
      lastValidQ  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_write_back                                                 |
// | Purpose  : Directed scoreboard bench for the writeback stage.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memToRegW;
  logic        regWriteW;
  logic [31:0] readDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  writeRegW;
  logic [1:0]  loadSizeW;
  logic        loadUnsW;
  logic [31:0] resultW;
  logic        rfWeW;
  logic [4:0]  rfWaddrW;
  logic [31:0] rfWdataW;
  logic [31:0] lastResultQ;
  logic [4:0]  lastRegQ;
  logic        lastValidQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  write_back #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .memToRegW(memToRegW), .regWriteW(regWriteW),
    .readDataW(readDataW), .ALUOutW(ALUOutW), .writeRegW(writeRegW),
    .loadSizeW(loadSizeW), .loadUnsW(loadUnsW), .resultW(resultW),
    .rfWeW(rfWeW), .rfWaddrW(rfWaddrW), .rfWdataW(rfWdataW),
    .lastResultQ(lastResultQ), .lastRegQ(lastRegQ), .lastValidQ(lastValidQ)
  );

  always #5 clk = ~clk;

  // Reference load formatter, written from the lane table rather than shifts.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
`ifdef WB_LOAD_EXT_EN
    case (off)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    if (size == 2'b10) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
`else
    b = 8'h0; h = 16'h0;
    return rd | {24'h0, b} | {16'h0, h} | {30'h0, off & size & {2{uns}} & 2'b00};
`endif
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      assert (act === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, act, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; memToRegW = 1'b0; regWriteW = 1'b1; readDataW = 32'h0;
    ALUOutW = 32'h11; writeRegW = 5'd7; loadSizeW = 2'b00; loadUnsW = 1'b0;

    // Reset: write suppressed, registers cleared, datapath still follows inputs
    #1;
    push(32'h0);  check("rst_we", {31'h0, rfWeW});
    push(32'h11); check("rst_result", resultW);
    push(32'd7);  check("rst_waddr", {27'h0, rfWaddrW});
    tick;
    push(32'h0); check("rst_lastres", lastResultQ);
    push(32'h0); check("rst_lastreg", {27'h0, lastRegQ});
    push(32'h0); check("rst_lastvld", {31'h0, lastValidQ});

    // Release: first edge captures the write
    rst_n = 1'b1; #1;
    push(32'h1); check("rel_we", {31'h0, rfWeW});
    tick;
    push(32'h11); check("rel_lastres", lastResultQ);
    push(32'd7);  check("rel_lastreg", {27'h0, lastRegQ});
    push(32'h1);  check("rel_lastvld", {31'h0, lastValidQ});

    // ALU result path
    ALUOutW = 32'd3; readDataW = 32'd1; writeRegW = 5'd5; #1;
    push(32'd3); check("alu_result", resultW);
    push(32'd3); check("alu_wdata", rfWdataW);
    push(32'h1); check("alu_we", {31'h0, rfWeW});
    push(32'd5); check("alu_waddr", {27'h0, rfWaddrW});
    tick;
    push(32'd3); check("alu_lastres", lastResultQ);
    push(32'd5); check("alu_lastreg", {27'h0, lastRegQ});

    // Memory word path
    memToRegW = 1'b1; #1;
    push(32'd1); check("mem_result", resultW);
    push(32'd1); check("mem_wdata", rfWdataW);
    tick;
    push(32'd1); check("mem_lastres", lastResultQ);

    // $0 write suppressed, registers hold
    memToRegW = 1'b0; writeRegW = 5'd0; ALUOutW = 32'hDEAD; #1;
    push(32'h0);    check("r0_we", {31'h0, rfWeW});
    push(32'hDEAD); check("r0_result", resultW);
    tick;
    push(32'h1); check("r0_lastvld", {31'h0, lastValidQ});
    push(32'd1); check("r0_lastres", lastResultQ);
    push(32'd5); check("r0_lastreg", {27'h0, lastRegQ});

    // regWriteW=0 also holds
    regWriteW = 1'b0; writeRegW = 5'd9; #1;
    push(32'h0); check("nowr_we", {31'h0, rfWeW});
    tick;
    push(32'd5); check("nowr_lastreg", {27'h0, lastRegQ});

    // Sub-word loads across every offset, size and extension mode
    memToRegW = 1'b1; readDataW = 32'h80FF7F01;
    for (int s = 0; s < 4; s++) begin
      for (int o = 0; o < 4; o++) begin
        for (int u = 0; u < 2; u++) begin
          loadSizeW = 2'(s); ALUOutW = 32'h1000 | 32'(o); loadUnsW = u[0]; #1;
          push(model_load(readDataW, 2'(o), 2'(s), u[0]));
          check($sformatf("load_s%0d_o%0d_u%0d", s, o, u), resultW);
        end
      end
    end

    // Spot values, independent of the model
    loadSizeW = 2'b10; ALUOutW = 32'd3; loadUnsW = 1'b0; #1;
`ifdef WB_LOAD_EXT_EN
    push(32'hFFFFFF80);
`else
    push(32'h80FF7F01);
`endif
    check("byte3_sext", resultW);
    loadSizeW = 2'b01; ALUOutW = 32'd2; #1;
`ifdef WB_LOAD_EXT_EN
    push(32'hFFFF80FF);
`else
    push(32'h80FF7F01);
`endif
    check("half1_sext", resultW);

    // Sub-word load retired, then mid-run reset clears it
    regWriteW = 1'b1; writeRegW = 5'd12; loadUnsW = 1'b1; ALUOutW = 32'd0; #1;
    tick;
    push(model_load(32'h80FF7F01, 2'd0, 2'b01, 1'b1)); check("half_lastres", lastResultQ);
    push(32'd12); check("half_lastreg", {27'h0, lastRegQ});
    rst_n = 1'b0; #1;
    push(32'h0); check("rst2_we", {31'h0, rfWeW});
    tick;
    push(32'h0); check("rst2_lastvld", {31'h0, lastValidQ});
    push(32'h0); check("rst2_lastres", lastResultQ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
